// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_pkg
// Description : Shared types and defaults for the countdown timer slice:
//               6-bit time-field type, timer FSM state encoding, default
//               hour/minute limits and a field clamp helper.
// Revision    : 1.0 - initial release
// ============================================================================
package clock_pkg;

    // One hours/minutes/seconds field
    typedef logic [5:0] time_field_t;

    // Timer FSM states, explicit 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam int c_MAX_HRS_DEFAULT = 23;
    localparam int c_MAX_MIN_DEFAULT = 59;

    // Saturate a preset field to its legal maximum
    function automatic time_field_t clamp_field(input time_field_t val,
                                                input time_field_t lim);
        return (val > lim) ? lim : val;
    endfunction

endpackage
`default_nettype wire

// File: rtl/down_counter.sv
`default_nettype none
// ============================================================================
// Module      : down_counter
// Description : One time field of the countdown chain. Decrements when
//               enabled, wraps from zero to wrap_val and raises borrow for
//               the next more-significant field in that same cycle.
//               A load always pre-empts counting and suppresses borrow.
// Revision    : 1.0 - initial release
// ============================================================================
module down_counter
    import clock_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       load,
    input  logic [5:0] load_val,
    input  logic [5:0] wrap_val,
    output logic [5:0] count,
    output logic       borrow
);

    assign borrow = en && !load && (count == 6'd0);

    // Field register: load beats decrement; zero wraps to the field maximum
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= 6'd0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= (count == 6'd0) ? wrap_val : (count - 6'd1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer
// Description : HH:MM:SS countdown timer driven by a one-second tick strobe.
//               States IDLE / RUN / PAUSED / EXPIRED; load > pause > start.
//               Optional macro COUNTDOWN_AUTO_RELOAD_EN: on expiry the count
//               reloads from a shadow copy of the last preset, done pulses
//               and the timer keeps running (expired never asserts).
// Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer
    import clock_pkg::*;
#(
    parameter int MAX_HRS = c_MAX_HRS_DEFAULT,
    parameter int MAX_MIN = c_MAX_MIN_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       load,
    input  logic [5:0] load_hrs,
    input  logic [5:0] load_min,
    input  logic [5:0] load_sec,
    input  logic       start,
    input  logic       pause,
    output logic [5:0] count_hrs,
    output logic [5:0] count_min,
    output logic [5:0] count_sec,
    output logic       running,
    output logic       done,
    output logic       expired
);

    localparam time_field_t c_MAX_HRS_F = MAX_HRS[5:0];
    localparam time_field_t c_MAX_MIN_F = MAX_MIN[5:0];

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_dec;
    logic        w_zero;
    logic        w_last;
    logic        w_expire;
    logic        w_cnt_load;
    logic        w_sec_borrow;
    logic        w_min_borrow;
    logic        w_hrs_borrow;
    time_field_t w_ld_hrs;
    time_field_t w_ld_min;
    time_field_t w_ld_sec;
    time_field_t w_val_hrs;
    time_field_t w_val_min;
    time_field_t w_val_sec;

    assign w_ld_hrs = clamp_field(load_hrs, c_MAX_HRS_F);
    assign w_ld_min = clamp_field(load_min, c_MAX_MIN_F);
    assign w_ld_sec = clamp_field(load_sec, c_MAX_MIN_F);

    // A tick only counts in the registered RUN state and loses to load
    assign w_dec  = (r_state == ST_RUN) && tick && !load;
    assign w_zero = (count_hrs == 6'd0) && (count_min == 6'd0) && (count_sec == 6'd0);
    assign w_last = w_dec && (count_hrs == 6'd0) && (count_min == 6'd0)
                    && (count_sec == 6'd1);
    // An hours borrow means a decrement from 00:00:00, which the FSM never
    // allows; fold it into expiry so the block cannot run on past zero.
    assign w_expire = w_last || w_hrs_borrow;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    localparam logic c_AUTO_RELOAD = 1'b1;

    time_field_t r_shadow_hrs;
    time_field_t r_shadow_min;
    time_field_t r_shadow_sec;

    // Shadow copy of the last clamped preset, replayed on every expiry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shadow_hrs <= 6'd0;
            r_shadow_min <= 6'd0;
            r_shadow_sec <= 6'd0;
        end else if (load) begin
            r_shadow_hrs <= w_ld_hrs;
            r_shadow_min <= w_ld_min;
            r_shadow_sec <= w_ld_sec;
        end
    end

    assign w_cnt_load = load || w_expire;
    assign w_val_hrs  = load ? w_ld_hrs : r_shadow_hrs;
    assign w_val_min  = load ? w_ld_min : r_shadow_min;
    assign w_val_sec  = load ? w_ld_sec : r_shadow_sec;
`else
    localparam logic c_AUTO_RELOAD = 1'b0;

    assign w_cnt_load = load;
    assign w_val_hrs  = w_ld_hrs;
    assign w_val_min  = w_ld_min;
    assign w_val_sec  = w_ld_sec;
`endif

    down_counter u_sec (
        .clk      (clk),
        .reset    (reset),
        .en       (w_dec),
        .load     (w_cnt_load),
        .load_val (w_val_sec),
        .wrap_val (c_MAX_MIN_F),
        .count    (count_sec),
        .borrow   (w_sec_borrow)
    );

    down_counter u_min (
        .clk      (clk),
        .reset    (reset),
        .en       (w_sec_borrow),
        .load     (w_cnt_load),
        .load_val (w_val_min),
        .wrap_val (c_MAX_MIN_F),
        .count    (count_min),
        .borrow   (w_min_borrow)
    );

    down_counter u_hrs (
        .clk      (clk),
        .reset    (reset),
        .en       (w_min_borrow),
        .load     (w_cnt_load),
        .load_val (w_val_hrs),
        .wrap_val (c_MAX_HRS_F),
        .count    (count_hrs),
        .borrow   (w_hrs_borrow)
    );

    // Next-state: load overrides all; a pending pause also blocks start;
    // expiry outranks a pause arriving on the final tick
    always_comb begin
        w_state_nxt = r_state;
        if (load) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_PAUSED: begin
                    if (!pause && start && !w_zero) w_state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    if (w_expire)   w_state_nxt = c_AUTO_RELOAD ? ST_RUN : ST_EXPIRED;
                    else if (pause) w_state_nxt = ST_PAUSED;
                end
                ST_EXPIRED: w_state_nxt = ST_EXPIRED;
                default:    w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State register with registered status decodes and done pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            running <= 1'b0;
            expired <= 1'b0;
            done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            running <= (w_state_nxt == ST_RUN);
            expired <= (w_state_nxt == ST_EXPIRED);
            done    <= w_expire;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_countdown_timer
// Description : Self-checking bench for countdown_timer. A reference model
//               tracks the remaining time as a plain number of seconds and
//               the mode as a small integer; every check compares the DUT
//               outputs against it and/or against fixed expected values.
//               Honours COUNTDOWN_AUTO_RELOAD_EN for the auto-reload build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_countdown_timer;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    localparam bit c_AUTO = 1'b1;
`else
    localparam bit c_AUTO = 1'b0;
`endif
    localparam int c_MAXH = 23;
    localparam int c_MAXM = 59;
    localparam int c_M_IDLE = 0, c_M_RUN = 1, c_M_PAUSED = 2, c_M_EXP = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick, load, start, pause;
    logic [5:0] load_hrs, load_min, load_sec;
    logic [5:0] count_hrs, count_min, count_sec;
    logic       running, done, expired;

    int n_checks = 0;
    int n_pass   = 0;
    int n_done   = 0;

    // Reference model state
    int m_tot    = 0;
    int m_shadow = 0;
    int m_mode   = c_M_IDLE;
    bit m_done   = 1'b0;

    countdown_timer dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .load      (load),
        .load_hrs  (load_hrs),
        .load_min  (load_min),
        .load_sec  (load_sec),
        .start     (start),
        .pause     (pause),
        .count_hrs (count_hrs),
        .count_min (count_min),
        .count_sec (count_sec),
        .running   (running),
        .done      (done),
        .expired   (expired)
    );

    always #5 clk = ~clk;

    function automatic int clampv(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    function automatic logic [20:0] dut_vec();
        return {count_hrs, count_min, count_sec, running, done, expired};
    endfunction

    function automatic logic [20:0] exp_vec();
        logic [5:0] h, m, s;
        h = 6'(m_tot / 3600);
        m = 6'((m_tot / 60) % 60);
        s = 6'(m_tot % 60);
        return {h, m, s, (m_mode == c_M_RUN), m_done, (m_mode == c_M_EXP)};
    endfunction

    task automatic model_reset();
        m_tot = 0; m_shadow = 0; m_mode = c_M_IDLE; m_done = 1'b0;
    endtask

    // Advance the model by one clock with the given inputs
    task automatic model_cycle(input bit t, input bit ld, input bit st, input bit ps,
                               input int h, input int m, input int s);
        bit fin;
        fin    = 1'b0;
        m_done = 1'b0;
        if (ld) begin
            m_tot    = clampv(h, c_MAXH) * 3600 + clampv(m, c_MAXM) * 60 + clampv(s, c_MAXM);
            m_shadow = m_tot;
            m_mode   = c_M_IDLE;
        end else begin
            case (m_mode)
                c_M_IDLE, c_M_PAUSED: if (!ps && st && m_tot != 0) m_mode = c_M_RUN;
                c_M_RUN: begin
                    if (t) begin
                        m_tot = m_tot - 1;
                        if (m_tot == 0) begin
                            fin    = 1'b1;
                            m_done = 1'b1;
                            if (c_AUTO) m_tot = m_shadow;
                            else        m_mode = c_M_EXP;
                        end
                    end
                    if (!fin && ps) m_mode = c_M_PAUSED;
                end
                default: ;
            endcase
        end
    endtask

    // Drive one cycle of inputs, update the model, sample 1 ns after the edge
    task automatic step(input bit t, input bit ld, input bit st, input bit ps,
                        input int h = 0, input int m = 0, input int s = 0);
        tick = t; load = ld; start = st; pause = ps;
        load_hrs = 6'(h); load_min = 6'(m); load_sec = 6'(s);
        model_cycle(t, ld, st, ps, h, m, s);
        @(posedge clk);
        #1;
        tick = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
        if (done) n_done++;
    endtask

    task automatic test_reset();
        reset = 1'b0; tick = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
        load_hrs = 6'd0; load_min = 6'd0; load_sec = 6'd0;
        model_reset();
        #2;
        n_checks++;
        if (dut_vec() !== 21'd0) $display("FAIL reset_async got=%h want=%h", dut_vec(), 21'd0);
        else n_pass++;
        @(posedge clk); @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk); #1;
        step(1'b1, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (dut_vec() !== exp_vec()) $display("FAIL reset_idle got=%h want=%h", dut_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_expiry();
        int d0;
        step(1'b0, 1'b1, 1'b0, 1'b0, 0, 1, 5);
        n_checks++;
        if (dut_vec() !== {6'd0, 6'd1, 6'd5, 3'b000}) $display("FAIL expiry_load got=%h", dut_vec());
        else n_pass++;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        d0 = n_done;
        for (int i = 0; i < 65; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (dut_vec() !== exp_vec()) $display("FAIL expiry_model got=%h want=%h", dut_vec(), exp_vec());
        else n_pass++;
        if (!c_AUTO) begin
            step(1'b1, 1'b0, 1'b1, 1'b1);
            n_checks++;
            if (dut_vec() !== {18'd0, 3'b001}) $display("FAIL expiry_hold got=%h want=%h", dut_vec(), {18'd0, 3'b001});
            else n_pass++;
            n_checks++;
            if (n_done - d0 !== 1) $display("FAIL expiry_done_count got=%0d want=1", n_done - d0);
            else n_pass++;
        end
    endtask

    task automatic test_borrow();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (dut_vec() !== {6'd0, 6'd59, 6'd59, 3'b100}) $display("FAIL borrow got=%h want=%h", dut_vec(), {6'd0, 6'd59, 6'd59, 3'b100});
        else n_pass++;
    endtask

    task automatic test_pause_resume();
        step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 10);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (dut_vec() !== {6'd0, 6'd0, 6'd7, 3'b000}) $display("FAIL paused got=%h want=%h", dut_vec(), {6'd0, 6'd0, 6'd7, 3'b000});
        else n_pass++;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (dut_vec() !== {6'd0, 6'd0, 6'd5, 3'b100}) $display("FAIL resumed got=%h want=%h", dut_vec(), {6'd0, 6'd0, 6'd5, 3'b100});
        else n_pass++;
    endtask

    task automatic test_clamp_and_zero();
        step(1'b0, 1'b1, 1'b0, 1'b0, 63, 63, 63);
        n_checks++;
        if (dut_vec() !== {6'd23, 6'd59, 6'd59, 3'b000}) $display("FAIL clamp got=%h want=%h", dut_vec(), {6'd23, 6'd59, 6'd59, 3'b000});
        else n_pass++;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 2, 3, 4);
        n_checks++;
        if (dut_vec() !== {6'd2, 6'd3, 6'd4, 3'b000}) $display("FAIL load_beats_tick got=%h want=%h", dut_vec(), {6'd2, 6'd3, 6'd4, 3'b000});
        else n_pass++;
        step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (dut_vec() !== 21'd0) $display("FAIL zero_start got=%h want=%h", dut_vec(), 21'd0);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 40);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (dut_vec() !== {6'd0, 6'd0, 6'd30, 3'b100}) $display("FAIL pre_reset got=%h want=%h", dut_vec(), {6'd0, 6'd0, 6'd30, 3'b100});
        else n_pass++;
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if (dut_vec() !== 21'd0) $display("FAIL mid_run_reset got=%h want=%h", dut_vec(), 21'd0);
        else n_pass++;
        model_reset();
        #4 reset = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (dut_vec() !== 21'd0) $display("FAIL post_reset_idle got=%h want=%h", dut_vec(), 21'd0);
        else n_pass++;
    endtask

    task automatic test_auto_reload();
        int d0;
        step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 2);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        d0 = n_done;
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (done !== (i == 2 || i == 4)) $display("FAIL auto_done tick=%0d got=%b", i, done);
            else n_pass++;
        end
        n_checks++;
        if (dut_vec() !== {6'd0, 6'd0, 6'd1, 3'b100}) $display("FAIL auto_final got=%h want=%h", dut_vec(), {6'd0, 6'd0, 6'd1, 3'b100});
        else n_pass++;
        n_checks++;
        if (n_done - d0 !== 2) $display("FAIL auto_done_count got=%0d want=2", n_done - d0);
        else n_pass++;
    endtask

    task automatic test_random();
        bit t, ld, st, ps;
        for (int i = 0; i < 600; i++) begin
            t  = ($urandom_range(0, 99) < 60);
            ld = ($urandom_range(0, 99) < 4);
            st = ($urandom_range(0, 99) < 12);
            ps = ($urandom_range(0, 99) < 5);
            if ($urandom_range(0, 3) == 0)
                step(t, ld, st, ps, $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63));
            else
                step(t, ld, st, ps, 0, $urandom_range(0, 1), $urandom_range(0, 20));
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL random cyc=%0d got=%h want=%h", i, dut_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_expiry();
        test_borrow();
        test_pause_resume();
        test_clamp_and_zero();
        test_async_reset();
        if (c_AUTO) test_auto_reload();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
